// File: rtl/cpu_pipeline_pkg.sv
// Shared pipeline definitions: default datapath widths, the LEGv8 NOP used
// for bubbles and flushes, the fetch entry layout, and a count-width helper.
package cpu_pipeline_pkg;

    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;

    // LEGv8 NOP; inserted wherever a pipeline register must present a bubble.
    localparam logic [31:0] NOP_INSTR = 32'hD503201F;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Width needed to hold an occupancy of 0..depth inclusive.
    function automatic int count_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_decode_queue_if.sv
// Fetch-side and decode-side valid/ready handshakes of the IF/ID queue.
// master: the pipeline stages driving the queue; slave: the queue itself.
interface fetch_decode_queue_if #(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32
);
    logic               fetch_valid;
    logic               fetch_ready;
    logic [ADDR_W-1:0]  fetch_pc;
    logic [INSTR_W-1:0] fetch_instr;
    logic               dec_valid;
    logic               dec_ready;
    logic [ADDR_W-1:0]  dec_pc;
    logic [INSTR_W-1:0] dec_instr;

    modport master (
        output fetch_valid, fetch_pc, fetch_instr, dec_ready,
        input  fetch_ready, dec_valid, dec_pc, dec_instr
    );

    modport slave (
        input  fetch_valid, fetch_pc, fetch_instr, dec_ready,
        output fetch_ready, dec_valid, dec_pc, dec_instr
    );
endinterface

// File: rtl/fdq_storage.sv
// Entry array for the fetch/decode queue: one synchronous write port and one
// combinational read port. Contents are meaningless until written, so no reset.
module fdq_storage #(
    parameter int DEPTH = 4,
    parameter int W     = 96,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wen,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem_q [DEPTH];

    // Write the addressed entry when the queue accepts a word.
    always_ff @(posedge clk) begin
        if (wen) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/fetch_decode_queue.sv
// DEPTH-entry FIFO of {PC, instruction} between fetch and decode. Decode sees
// the head entry combinationally (NOP and PC 0 when empty); flush empties the
// queue and wins over any same-cycle push or pop.
module fetch_decode_queue
    import cpu_pipeline_pkg::*;
#(
    parameter int                 INSTR_W   = cpu_pipeline_pkg::INSTR_W,
    parameter int                 ADDR_W    = cpu_pipeline_pkg::ADDR_W,
    parameter int                 DEPTH     = 4,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(cpu_pipeline_pkg::NOP_INSTR),
    parameter int                 CNT_W     = count_w(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    fetch_decode_queue_if.slave    q_if,
    input  logic                   flush,
    output logic [CNT_W-1:0]       count,
    output logic                   overflow_err
);
    localparam int               PTR_W    = $clog2(DEPTH);
    localparam int               ENT_W    = ADDR_W + INSTR_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             full, empty, push, pop;
    logic [ENT_W-1:0] rd_data;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    // When full, fetch_ready stays low even if decode pops this cycle, so the
    // ready path never depends on dec_ready.
    assign push = q_if.fetch_valid && !full;
    assign pop  = !empty && q_if.dec_ready;

    // Next pointer/count/error state; flush overrides push and pop.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (q_if.fetch_valid && full) begin
                overflow_d = 1'b1;
            end
            if (push) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state with asynchronous clear; entries themselves are not reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    fdq_storage #(
        .DEPTH (DEPTH),
        .W     (ENT_W),
        .AW    (PTR_W)
    ) u_storage (
        .clk   (clk),
        .wen   (push && !flush),
        .waddr (tail_q),
        .wdata ({q_if.fetch_pc, q_if.fetch_instr}),
        .raddr (head_q),
        .rdata (rd_data)
    );

    assign q_if.fetch_ready = !full;
    assign q_if.dec_valid   = !empty;
    assign q_if.dec_pc      = empty ? '0 : rd_data[ENT_W-1:INSTR_W];
    assign q_if.dec_instr   = empty ? NOP_INSTR : rd_data[INSTR_W-1:0];
    assign count            = count_q;
    assign overflow_err     = overflow_q;
endmodule

// File: tb/tb_fetch_decode_queue.sv
// Bench for fetch_decode_queue: a queue-based reference model of the IF/ID
// FIFO, checked against the DUT every falling edge, plus literal spot checks.
module tb_fetch_decode_queue;
    import cpu_pipeline_pkg::*;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'hD503201F;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic [2:0] count;
    logic       overflow_err;

    fetch_decode_queue_if #(.ADDR_W(64), .INSTR_W(32)) bus ();

    fetch_decode_queue #(.INSTR_W(32), .ADDR_W(64), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .q_if         (bus.slave),
        .flush        (flush),
        .count        (count),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    fetch_entry_t m_q[$];
    logic         m_ovf = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference behaviour at a rising edge, from the values presented before it.
    task automatic model_edge();
        int  sz;
        bit  acc, take;
        sz = m_q.size();
        if (reset) begin
            m_q.delete();
            m_ovf = 1'b0;
        end else if (flush) begin
            m_q.delete();
        end else begin
            acc  = bus.fetch_valid && (sz < DEPTH);
            take = bus.dec_ready && (sz > 0);
            if (bus.fetch_valid && sz == DEPTH) m_ovf = 1'b1;
            if (take) void'(m_q.pop_front());
            if (acc) m_q.push_back('{pc: bus.fetch_pc, instr: bus.fetch_instr});
        end
    endtask

    task automatic step(input logic fv, input logic [63:0] pc, input logic dr, input logic fl);
        bus.fetch_valid = fv;
        bus.fetch_pc    = pc;
        bus.fetch_instr = pc[31:0] + 32'h1000;
        bus.dec_ready   = dr;
        flush           = fl;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Every falling edge: DUT outputs against the model.
    always @(negedge clk) begin
        int sz;
        sz = m_q.size();
        chk("dec_valid", bus.dec_valid, sz != 0);
        chk("fetch_ready", bus.fetch_ready, sz < DEPTH);
        chk("count", count, sz);
        chk("overflow_err", overflow_err, m_ovf);
        chk("dec_pc", bus.dec_pc, (sz != 0) ? m_q[0].pc : 64'd0);
        chk("dec_instr", bus.dec_instr, (sz != 0) ? m_q[0].instr : NOP);
    end

    initial begin
        logic [63:0] next_pc;
        reset = 1'b1;
        flush = 1'b0;
        bus.fetch_valid = 1'b0;
        bus.fetch_pc    = '0;
        bus.fetch_instr = '0;
        bus.dec_ready   = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;

        // Reset then idle
        for (int i = 0; i < 3; i++) step(1'b0, 64'd0, 1'b1, 1'b0);
        chk("idle_valid", bus.dec_valid, 0);
        chk("idle_instr", bus.dec_instr, 32'hD503201F);
        chk("idle_pc", bus.dec_pc, 0);
        chk("idle_count", count, 0);
        chk("idle_ready", bus.fetch_ready, 1);

        // Streaming: each word visible one cycle after its push
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 64'(4 * k), 1'b1, 1'b0);
            chk("stream_pc", bus.dec_pc, 64'(4 * k));
            chk("stream_instr", bus.dec_instr, 64'(4 * k + 32'h1000));
            chk("stream_count", count, 1);
        end
        step(1'b0, 64'd0, 1'b1, 1'b0);

        // Fill and stall
        for (int k = 0; k < 4; k++) step(1'b1, 64'(4 * k), 1'b0, 1'b0);
        chk("fill_count", count, 4);
        chk("fill_ready", bus.fetch_ready, 0);
        chk("fill_ovf_before", overflow_err, 0);
        step(1'b1, 64'd16, 1'b0, 1'b0);
        chk("fill_ovf", overflow_err, 1);
        chk("fill_count_held", count, 4);
        for (int k = 0; k < 4; k++) begin
            chk("drain_pc", bus.dec_pc, 64'(4 * k));
            step(1'b0, 64'd0, 1'b1, 1'b0);
        end
        chk("drain_count", count, 0);

        // Wrap-around with decode toggling; fetch holds a word until accepted
        next_pc = 64'd200;
        for (int i = 0; i < 10; i++) begin
            bit acc;
            acc = m_q.size() < DEPTH;
            step(1'b1, next_pc, (i % 2) == 0, 1'b0);
            if (acc) next_pc = next_pc + 64'd4;
            chk("wrap_count_le4", count <= 3'd4, 1);
        end
        for (int i = 0; i < 8; i++) step(1'b0, 64'd0, 1'b1, 1'b0);
        chk("wrap_drained", count, 0);

        // Flush with concurrent push and pop
        step(1'b1, 64'd20, 1'b0, 1'b0);
        step(1'b1, 64'd24, 1'b0, 1'b0);
        step(1'b1, 64'd28, 1'b0, 1'b0);
        chk("pre_flush_count", count, 3);
        step(1'b1, 64'd32, 1'b1, 1'b1);
        chk("flush_count", count, 0);
        chk("flush_valid", bus.dec_valid, 0);
        chk("flush_instr", bus.dec_instr, 32'hD503201F);
        chk("flush_ready", bus.fetch_ready, 1);
        step(1'b0, 64'd0, 1'b1, 1'b0);
        chk("flush_no32", bus.dec_valid, 0);
        step(1'b1, 64'd100, 1'b0, 1'b0);
        chk("post_flush_pc", bus.dec_pc, 100);
        chk("post_flush_valid", bus.dec_valid, 1);
        step(1'b0, 64'd0, 1'b1, 1'b0);

        // Asynchronous reset mid-stream
        step(1'b1, 64'd40, 1'b0, 1'b0);
        step(1'b1, 64'd44, 1'b0, 1'b0);
        step(1'b1, 64'd48, 1'b0, 1'b0);
        chk("pre_reset_count", count, 3);
        #2 reset = 1'b1;
        m_q.delete();
        m_ovf = 1'b0;
        #1;
        chk("async_count", count, 0);
        chk("async_valid", bus.dec_valid, 0);
        chk("async_ovf", overflow_err, 0);
        chk("async_instr", bus.dec_instr, 32'hD503201F);
        step(1'b0, 64'd0, 1'b1, 1'b0);
        reset = 1'b0;
        step(1'b1, 64'd60, 1'b0, 1'b0);
        chk("resume_pc", bus.dec_pc, 60);
        chk("resume_count", count, 1);
        step(1'b0, 64'd0, 1'b1, 1'b0);
        chk("resume_drain", count, 0);

        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_decode_queue.md
Name: fetch_decode_queue

Overview:
Parametrised replacement for the single-entry IF/ID register between instruction fetch and decode in the pipelined CPU. It is a DEPTH-entry FIFO of {PC, instruction} pairs with valid/ready handshakes on both sides. Decode-side backpressure stalls fetch instead of dropping words. A synchronous flush squashes wrong-path instructions on a taken branch. When empty, decode is fed a NOP, so the startup bubble and post-flush bubbles are explicit.

Parameters:
INSTR_W, 32, instruction width in bits
ADDR_W, 64, PC width in bits
DEPTH, 4, queue entries; power of two, minimum 2
NOP_INSTR, 32'hD503201F, instruction presented on dec_instr when the queue is empty

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high; clears the queue
fetch_valid  input  1  fetch presents a word this cycle
fetch_ready  output  1  queue accepts a word this cycle; equals !full
fetch_pc  input  ADDR_W  PC of the fetched word
fetch_instr  input  INSTR_W  fetched instruction
dec_valid  output  1  head entry is valid; equals !empty
dec_ready  input  1  decode consumes the head this cycle; low means hazard stall
dec_pc  output  ADDR_W  PC of the head entry; 0 when empty
dec_instr  output  INSTR_W  head instruction; NOP_INSTR when empty
flush  input  1  squash all queued and incoming words
count  output  $clog2(DEPTH+1)  current occupancy
overflow_err  output  1  sticky flag: push attempted while full; cleared only by reset

Behaviour:
- Reset (asynchronous assert, released on a clock edge):
  - Pointers and count = 0.
  - dec_valid = 0, fetch_ready = 1, dec_pc = 0, dec_instr = NOP_INSTR, overflow_err = 0.
  - Entry storage contents are don't-care.
- Push: fetch_valid && fetch_ready at a rising edge writes {fetch_pc, fetch_instr} to the tail; the tail pointer increments modulo DEPTH.
- Pop: dec_valid && dec_ready at a rising edge advances the head pointer modulo DEPTH.
- Latency:
  - A word pushed into an empty queue appears on dec_* one cycle after the push edge. This is the same one-cycle IF→ID delay as the old register.
  - The queue has no combinational fetch→decode bypass.
- Outputs: dec_* are driven combinationally from the head entry. When empty they are muxed to NOP_INSTR and 0.
- Simultaneous push and pop:
  - Not full, not empty: both happen and count is unchanged.
  - Empty: only the push occurs, since no pop is possible when empty.
  - Full: fetch_ready is low, so only the pop occurs. No same-cycle slot reuse when full (decided; it keeps fetch_ready registered-path clean).
- Count: count = number of entries, 0..DEPTH. Full when count == DEPTH; empty when count == 0. Pointers are log2(DEPTH) bits and wrap naturally.
- Flush:
  - Takes priority over push and pop in the same cycle.
  - At the edge: head = tail = 0, count = 0. Any concurrent push is discarded and any concurrent pop is not counted.
  - Next cycle: dec_valid = 0 and dec_instr = NOP_INSTR.
  - fetch_ready is 1 in the cycle after the flush.
- Overflow: fetch_valid && !fetch_ready && !flush sets overflow_err at the edge. The queue state is unaffected.
- Underflow: dec_ready while empty is ignored, with no error flag; a decode-stalled empty queue is legal.
- Reset mid-operation: all in-flight entries are lost. Outputs take reset values immediately, without waiting for a clock edge.

Decomposition:
- Shared package cpu_pipeline_pkg holds:
  - the NOP_INSTR constant (LEGv8 NOP), reused by the ID/EX and EX/MEM flush logic;
  - typedef fetch_entry_t, a packed struct {pc, instr} sized by the package's ADDR_W and INSTR_W;
  - the count width function.
- One sub-module: fdq_storage, the DEPTH×(ADDR_W+INSTR_W) register array. It has a write port (wen, waddr, wdata) and a combinational read port (raddr, rdata), and no reset.
- The pointers, count, flush and error logic stay in fetch_decode_queue.

Test Plan:
- Reset then idle, with fetch_valid=0 and dec_ready=1 for 3 cycles → dec_valid=0, dec_instr=32'hD503201F, dec_pc=0, count=0, fetch_ready=1.
- Streaming: push PC=0,4,8,… with instr=PC+32'h1000 every cycle, dec_ready=1 → each word appears on dec_* exactly 1 cycle after its push; count stays at 1; no bubbles after the first.
- Fill and stall: DEPTH=4, dec_ready=0, push PCs 0..16 → after 4 pushes count=4 and fifth cycle fetch_ready=0; a push attempted while full sets overflow_err=1 and count stays 4. Then set dec_ready=1 → dec_pc sequence 0,4,8,12; count drains to 0.
- Wrap-around: 10 push/pop cycles with dec_ready toggling 1,0 → dec_pc matches push order with no duplication or loss across pointer wrap; count never exceeds 4.
- Flush with concurrent push/pop: queue holds PCs 20,24,28; assert flush with fetch_valid=1 (PC=32) and dec_ready=1 → next cycle count=0, dec_valid=0, dec_instr=NOP; PC 32 is never presented; a push of PC=100 one cycle later appears as dec_pc=100 one cycle after that push.
- Asynchronous reset mid-stream: assert reset between clock edges while count=3 → count=0, dec_valid=0 and overflow_err=0 without waiting for a clock edge; normal operation resumes on the first edge after release.
